// File: rtl/ft_tx_arbiter.sv
// Round-robin arbiter sharing the FT600 245-mode write path between N_REQ burst requesters.
// Optional FT_TX_HDR_EN: prefixes each burst with one header word {4'hA, owner, len[7:0]}.
module ft_tx_arbiter #(
  parameter int DATA_W = 16,
  parameter int BE_W   = 2,
  parameter int N_REQ  = 3,
  parameter int LEN_W  = 24
) (
  input  logic                    i_ft_clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*LEN_W-1:0]  i_len,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  input  logic [N_REQ-1:0]        i_valid,
  output logic [N_REQ-1:0]        o_ready,
  input  logic                    i_ft_txe_n,
  output logic                    o_ft_wr_n,
  output logic [DATA_W-1:0]       o_ft_data,
  output logic [BE_W-1:0]         o_ft_be,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_busy,
  output logic [N_REQ-1:0]        o_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
`ifdef FT_TX_HDR_EN
    HDR,
`endif
    XFER,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  rr_ptr, owner, winner;
  logic              any_req, found;
  logic [LEN_W-1:0]  remaining, sel_len;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid, xfer_open, accept;

`ifdef FT_TX_HDR_EN
  logic [15:0] hdr_word;
  assign hdr_word = {4'hA, 4'(owner), remaining[7:0]};
`endif

  assign any_req = |i_req;

  // First pass takes the lowest request at or above rr_ptr; otherwise wrap to the lowest overall.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k] && (IDX_W'(k) >= rr_ptr)) begin
        winner = IDX_W'(k);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (i_req[k]) winner = IDX_W'(k);
      end
    end
  end

  always_comb begin
    sel_len   = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner == IDX_W'(k)) begin
        sel_len   = i_len[k*LEN_W +: LEN_W];
        sel_data  = i_data[k*DATA_W +: DATA_W];
        sel_valid = i_valid[k];
      end
    end
  end

  assign xfer_open = (state == XFER) && !i_ft_txe_n && (remaining != '0);
  assign accept    = xfer_open && sel_valid;
  assign o_busy    = (state != IDLE);

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_ready[k] = xfer_open && (owner == IDX_W'(k));
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (any_req) state_n = GRANT;
`ifdef FT_TX_HDR_EN
      GRANT: state_n = HDR;
      HDR:   if (!i_ft_txe_n) state_n = XFER;
`else
      GRANT: state_n = XFER;
`endif
      XFER: begin
        if (remaining == '0)                          state_n = DONE;
        else if (accept && remaining == LEN_W'(1))    state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_ft_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Registered outputs: a strobe appears exactly one cycle after its accept.
  always_ff @(posedge i_ft_clk or posedge rst) begin
    if (rst) begin
      o_ft_wr_n <= 1'b1;
      o_ft_data <= '0;
      o_ft_be   <= '0;
      o_grant   <= '0;
      o_done    <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      remaining <= '0;
    end else begin
      o_ft_wr_n <= 1'b1;
      o_ft_be   <= '0;
      o_done    <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner;
            for (int k = 0; k < N_REQ; k++) o_grant[k] <= (winner == IDX_W'(k));
          end
        end
        GRANT: remaining <= sel_len;
`ifdef FT_TX_HDR_EN
        HDR: begin
          if (!i_ft_txe_n) begin
            o_ft_wr_n <= 1'b0;
            o_ft_be   <= '1;
            o_ft_data <= DATA_W'(hdr_word);
          end
        end
`endif
        XFER: begin
          if (accept) begin
            o_ft_wr_n <= 1'b0;
            o_ft_be   <= '1;
            o_ft_data <= sel_data;
            remaining <= remaining - 1'b1;
          end
          if (state_n == DONE) o_done <= o_grant;
        end
        DONE: begin
          o_grant <= '0;
          rr_ptr  <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ft_tx_arbiter.md
Name: ft_tx_arbiter

Overview:
Shares the FT600 245-mode write path between up to N requesters, such as the ADC capture readout, the loopback/echo responder and the status counter. Each requester asks for a burst of a fixed word count and streams words over valid/ready. The arbiter grants one requester at a time with round-robin fairness and drives o_ft_wr_n, data and byte-enables with TXE_N flow control. It sits between the command decoder/datapath sources and the FT600 tristate pad logic.

Parameters:
DATA_W, 16, FT600 data width in bits
BE_W, 2, byte-enable width
N_REQ, 3, number of requesters (2..8)
LEN_W, 24, burst length counter width, in words

Ports:
i_ft_clk  in  1  FT600 60/100 MHz clock; the only clock
rst  in  1  asynchronous active-high reset
i_req  in  N_REQ  per-requester burst request level
i_len  in  N_REQ*LEN_W  burst length in words; slice k is requester k; sampled at grant
i_data  in  N_REQ*DATA_W  write data; slice k is requester k
i_valid  in  N_REQ  per-requester data valid
o_ready  out  N_REQ  per-requester data accept; at most one bit high
i_ft_txe_n  in  1  FT600 TX FIFO not-ready, active low
o_ft_wr_n  out  1  FT600 write strobe, active low, registered
o_ft_data  out  DATA_W  write data to pad mux, registered
o_ft_be  out  BE_W  byte enables, registered; all ones while writing, else 0
o_grant  out  N_REQ  one-hot current owner, registered; 0 when idle
o_busy  out  1  high when not in IDLE
o_done  out  N_REQ  one-cycle pulse to the owner when its burst completes

Behaviour:
- Reset values (asynchronous): o_ft_wr_n=1, o_ft_data=0, o_ft_be=0, o_grant=0, o_busy=0, o_done=0, o_ready=0, state=IDLE, rr_ptr=0, remaining=0.
- States: IDLE, GRANT, [HDR], XFER, DONE.
- IDLE → GRANT when any i_req is set:
  - Winner is the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - o_grant is set to the winner's one-hot code.
- GRANT: latch remaining = i_len[winner]. Next state is HDR if enabled, else XFER.
- XFER: o_ready[g] = (state==XFER) & ~i_ft_txe_n & (remaining!=0). This is combinational and gated only by owner, state, remaining and TXE_N.
- Accept happens when i_valid[g] & o_ready[g]:
  - Next cycle: o_ft_wr_n=0, o_ft_data=the accepted word, o_ft_be=all ones.
  - remaining decrements by 1.
  - Latency from accept to strobe is exactly 1 cycle.
- No accept in a cycle → next cycle o_ft_wr_n=1, o_ft_be=0, o_ft_data holds its last value.
- i_ft_txe_n high mid-burst stalls acceptance with no word lost and no duplicate strobe. A word already registered is still strobed: the FT600 tolerates one write after TXE_N rises.
- remaining reaching 0 after an accept → DONE.
- i_len=0 → GRANT goes to XFER and on to DONE with no write strobe.
- DONE (1 cycle):
  - o_done[g] pulses.
  - rr_ptr = (g+1) mod N_REQ.
  - o_grant clears; next state is IDLE.
- A requester that drops i_req or i_valid mid-burst does not abort the burst. The arbiter waits indefinitely for the remaining words.
- A requester re-requesting in the same cycle as its own o_done is arbitrated normally in IDLE; round-robin then favours the others.
- Requester k must hold i_req until o_done[k]. An i_req that is not granted is never lost.
- remaining is LEN_W bits and burst length tops out at 2^LEN_W-1 words; there is no wrap.
- Reset asserted mid-burst aborts immediately: outputs return to reset values and no o_done is issued.

Optional Feature:
FT_TX_HDR_EN:
- Defined: GRANT is followed by HDR, which waits for ~i_ft_txe_n and then writes one header word. For DATA_W=16 the header is {4'hA, 4'(g), 8'(i_len[g][7:0])}, with one strobe and no o_ready. The state then moves to XFER. The header is emitted even when len=0.
- Undefined: the HDR state is absent; GRANT goes directly to XFER.

Test Plan:
- Single burst: only req1, len=4, valid held high, TXE_N low → 4 consecutive wr_n=0 cycles carrying the data in order, then o_done[1] pulses once and o_grant returns to 0.
- Round-robin: req0 and req2 held high continuously, len=2 each, from reset → grant order 0,2,0,2; no requester is granted twice in a row while the other waits.
- Backpressure: len=6 with TXE_N high for 3 cycles after word 2 → exactly 6 strobes total, no duplicated or dropped data values, and o_ready=0 while TXE_N is high.
- Zero length: req0 len=0 → o_done[0] pulses 3 cycles after the request is seen, with no wr_n strobe (with FT_TX_HDR_EN: exactly 1 header strobe).
- Valid gaps: len=3 with i_valid toggling 1,0,1,0,1 → 3 strobes whose spacing matches the accepts, and remaining returns to 0.
- Reset mid-burst: assert rst after 2 of 5 words → wr_n=1, grant=0, be=0 asynchronously and no o_done; after release a fresh req1 len=1 completes normally.
